pipe_ctrl_unit: RTL and testbench

Consumes the main decoder's per-opcode control bundle in ID and carries it through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use hazards, resolves branch/jump/jal/jr into a PC-select, and generates stall and flush. It sits between the main decoder, the hazard-free datapath registers and the PC mux. It also keeps saturating stall/flush event counters for on-FPGA debug.

---
 rtl/mips_ctrl_pkg.sv | 58 +++++
 rtl/ctrl_hazard_detect.sv | 36 +++
 rtl/pipe_ctrl_unit.sv | 185 ++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the pipeline control unit:
//   - PC-select encodings driven to the PC mux
//   - register-file constants (REG_RA is the jal link register)
//   - packed control bundles held in the ID/EX, EX/MEM and MEM/WB registers
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int REG_W   = 5;
    localparam int ALUOP_W = 2;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;  // PC + 4
    localparam logic [1:0] PC_SEL_BR  = 2'd1;  // branch target
    localparam logic [1:0] PC_SEL_J   = 2'd2;  // jump target
    localparam logic [1:0] PC_SEL_JR  = 2'd3;  // register (jr)

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic               reg_dst;
        logic               alusrc;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               memto_reg;
        logic               reg_write;
        logic [ALUOP_W-1:0] aluop;
        logic [REG_W-1:0]   dst;
    } idex_ctrl_t;

    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             memto_reg;
        logic             reg_write;
        logic [REG_W-1:0] dst;
    } exmem_ctrl_t;

    typedef struct packed {
        logic             memto_reg;
        logic             reg_write;
        logic [REG_W-1:0] dst;
    } memwb_ctrl_t;

    // jal links into $ra; otherwise R-type writes rd and I-type writes rt.
    function automatic logic [REG_W-1:0] resolve_dst(
        input logic             jal,
        input logic             reg_dst,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd
    );
        if (jal)          return REG_RA;
        else if (reg_dst) return rd;
        else              return rt;
    endfunction

endpackage

// File: rtl/ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// ctrl_hazard_detect
// Combinational load-use detector. A load in EX whose destination feeds the
// instruction in ID must hold that instruction for one cycle.
// Ports:
//   ex_mem_read_i  - instruction in EX is a load
//   ex_dst_i       - destination register of the instruction in EX
//   id_rs_i/rt_i   - source fields of the instruction in ID
//   id_alusrc_i, id_mem_write_i, id_branch_i - decide whether ID reads rt
//   load_use_o     - stall request
// -----------------------------------------------------------------------------
import mips_ctrl_pkg::*;

module ctrl_hazard_detect (
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_dst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_alusrc_i,
    input  logic             id_mem_write_i,
    input  logic             id_branch_i,
    output logic             load_use_o
);

    logic rt_use;

    // rt is a real source for register-operand ALU ops, stores (data) and
    // branches (compare); immediate ALU ops and loads only use rs.
    assign rt_use = ~id_alusrc_i | id_mem_write_i | id_branch_i;

    // $zero never carries a dependency.
    assign load_use_o = ex_mem_read_i
                      & (ex_dst_i != '0)
                      & ((ex_dst_i == id_rs_i) | ((ex_dst_i == id_rt_i) & rt_use));

endmodule

// File: rtl/pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_unit
// Carries the decoder's control bundle from ID through ID/EX, EX/MEM, MEM/WB,
// resolves control flow into a PC select, and generates stall/flush.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   id_*                - decoder bundle and register fields for ID
//   ex_zero             - ALU zero flag for the instruction in EX
//   ex_*, mem_*, wb_*   - registered stage control
//   pc_write, ifid_write, ifid_flush, pc_sel - combinational front-end control
//   stall_cnt, flush_cnt - saturating debug event counters
// -----------------------------------------------------------------------------
import mips_ctrl_pkg::*;

module pipe_ctrl_unit #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_RegDst,
    input  logic              id_Branch,
    input  logic              id_MemRead,
    input  logic              id_MemtoReg,
    input  logic              id_MemWrite,
    input  logic              id_ALUsrc,
    input  logic              id_RegWrite,
    input  logic              id_jump,
    input  logic              id_jal,
    input  logic              id_jr,
    input  logic [1:0]        id_ALUop,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              ex_zero,
    output logic              ex_RegDst,
    output logic              ex_ALUsrc,
    output logic              ex_Branch,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic [1:0]        ex_ALUop,
    output logic [4:0]        ex_dst,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic              mem_MemtoReg,
    output logic              mem_RegWrite,
    output logic [4:0]        mem_dst,
    output logic              wb_MemtoReg,
    output logic              wb_RegWrite,
    output logic [4:0]        wb_dst,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [1:0]        pc_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    idex_ctrl_t       ex_q,  ex_d;
    exmem_ctrl_t      mem_q, mem_d;
    memwb_ctrl_t      wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic br_taken;
    logic bubble;
    logic stall_event;

    ctrl_hazard_detect u_hazard (
        .ex_mem_read_i  (ex_q.mem_read),
        .ex_dst_i       (ex_q.dst),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_alusrc_i    (id_ALUsrc),
        .id_mem_write_i (id_MemWrite),
        .id_branch_i    (id_Branch),
        .load_use_o     (load_use)
    );

    assign br_taken = ex_q.branch & ex_zero;

    // Front-end control, highest priority first.
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path leaves a signal unassigned and infers a latch.
        pc_sel     = PC_SEL_SEQ;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        bubble     = 1'b0;
        if (br_taken) begin
            // Kills IF and ID: ID is replaced by the bubble.
            pc_sel     = PC_SEL_BR;
            ifid_flush = 1'b1;
            bubble     = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
        end else if (id_jr) begin
            pc_sel     = PC_SEL_JR;
            ifid_flush = 1'b1;
        end else if (id_jump) begin
            pc_sel     = PC_SEL_J;
            ifid_flush = 1'b1;
        end
    end

    // A squashed branch means the load it overlapped never stalls.
    assign stall_event = load_use & ~br_taken;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.reg_dst   = id_RegDst;
            ex_d.alusrc    = id_ALUsrc;
            ex_d.branch    = id_Branch;
            ex_d.mem_read  = id_MemRead;
            ex_d.mem_write = id_MemWrite;
            ex_d.memto_reg = id_MemtoReg;
            ex_d.reg_write = id_RegWrite | id_jal;  // jal always links
            ex_d.aluop     = id_ALUop;
            ex_d.dst       = resolve_dst(id_jal, id_RegDst, id_rt, id_rd);
        end

        mem_d.mem_read  = ex_q.mem_read;
        mem_d.mem_write = ex_q.mem_write;
        mem_d.memto_reg = ex_q.memto_reg;
        mem_d.reg_write = ex_q.reg_write;
        mem_d.dst       = ex_q.dst;

        wb_d.memto_reg  = mem_q.memto_reg;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.dst        = mem_q.dst;

        stall_cnt_d = stall_cnt_q;
        if (stall_event && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        flush_cnt_d = flush_cnt_q;
        if (ifid_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_RegDst    = ex_q.reg_dst;
    assign ex_ALUsrc    = ex_q.alusrc;
    assign ex_Branch    = ex_q.branch;
    assign ex_MemRead   = ex_q.mem_read;
    assign ex_MemWrite  = ex_q.mem_write;
    assign ex_MemtoReg  = ex_q.memto_reg;
    assign ex_RegWrite  = ex_q.reg_write;
    assign ex_ALUop     = ex_q.aluop;
    assign ex_dst       = ex_q.dst;
    assign mem_MemRead  = mem_q.mem_read;
    assign mem_MemWrite = mem_q.mem_write;
    assign mem_MemtoReg = mem_q.memto_reg;
    assign mem_RegWrite = mem_q.reg_write;
    assign mem_dst      = mem_q.dst;
    assign wb_MemtoReg  = wb_q.memto_reg;
    assign wb_RegWrite  = wb_q.reg_write;
    assign wb_dst       = wb_q.dst;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_unit
// Directed scenarios followed by random decoder traffic. A reference model
// tracks the instruction occupying each of EX, MEM and WB and pushes the
// expected observable state for every cycle into a queue; an independent
// monitor pops and compares once per cycle.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite;
    logic id_ALUsrc, id_RegWrite, id_jump, id_jal, id_jr;
    logic [1:0] id_ALUop;
    logic [4:0] id_rs, id_rt, id_rd;
    logic ex_zero;
    logic ex_RegDst, ex_ALUsrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite;
    logic [1:0] ex_ALUop;
    logic [4:0] ex_dst;
    logic mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite;
    logic [4:0] mem_dst;
    logic wb_MemtoReg, wb_RegWrite;
    logic [4:0] wb_dst;
    logic pc_write, ifid_write, ifid_flush;
    logic [1:0] pc_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_RegDst(id_RegDst), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
        .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite), .id_ALUsrc(id_ALUsrc),
        .id_RegWrite(id_RegWrite), .id_jump(id_jump), .id_jal(id_jal), .id_jr(id_jr),
        .id_ALUop(id_ALUop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_zero(ex_zero),
        .ex_RegDst(ex_RegDst), .ex_ALUsrc(ex_ALUsrc), .ex_Branch(ex_Branch),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_ALUop(ex_ALUop), .ex_dst(ex_dst),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_MemtoReg(mem_MemtoReg), .mem_RegWrite(mem_RegWrite), .mem_dst(mem_dst),
        .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite), .wb_dst(wb_dst),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .pc_sel(pc_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Decoder view of one instruction.
    typedef struct {
        bit reg_dst, branch, mem_read, memto_reg, mem_write, alusrc, reg_write;
        bit jump, jal, jr;
        int aluop, rs, rt, rd;
    } inst_t;

    // What an instruction looks like once it has left ID.
    typedef struct {
        bit reg_dst, alusrc, branch, mem_read, mem_write, memto_reg, reg_write;
        int aluop, dst;
    } slot_t;

    typedef struct {
        int ex_bits, ex_dst, mem_bits, mem_dst, wb_bits, wb_dst;
        int pc_sel, pc_write, ifid_write, ifid_flush, stall, flush;
    } obs_t;

    obs_t  exp_q[$];
    slot_t m_ex, m_mem, m_wb;
    int    m_stall, m_flush;
    bit    model_ok = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic inst_t nop();
        inst_t i;
        i = '{default: 0};
        return i;
    endfunction

    function automatic int ex_bits_of(input slot_t s);
        return (int'(s.reg_dst) << 8) | (int'(s.alusrc) << 7) | (int'(s.branch) << 6)
             | (int'(s.mem_read) << 5) | (int'(s.mem_write) << 4) | (int'(s.memto_reg) << 3)
             | (int'(s.reg_write) << 2) | s.aluop;
    endfunction

    // One cycle: drive inputs, predict what the DUT shows this cycle, then
    // advance the model to what it holds after the edge.
    task automatic step(input inst_t i, input bit zero, input bit r);
        obs_t  o;
        slot_t nxt;
        bit    br, lu, reads_rt, bubble, stall_ev;
        @(negedge clk);
        rst = r; ex_zero = zero;
        id_RegDst = i.reg_dst; id_Branch = i.branch; id_MemRead = i.mem_read;
        id_MemtoReg = i.memto_reg; id_MemWrite = i.mem_write; id_ALUsrc = i.alusrc;
        id_RegWrite = i.reg_write; id_jump = i.jump; id_jal = i.jal; id_jr = i.jr;
        id_ALUop = 2'(i.aluop); id_rs = 5'(i.rs); id_rt = 5'(i.rt); id_rd = 5'(i.rd);

        br       = m_ex.branch && zero;
        reads_rt = !i.alusrc || i.mem_write || i.branch;
        lu       = m_ex.mem_read && m_ex.dst != 0
                   && (m_ex.dst == i.rs || (m_ex.dst == i.rt && reads_rt));
        o.pc_sel = 0; o.pc_write = 1; o.ifid_write = 1; o.ifid_flush = 0; bubble = 0;
        if (br) begin
            o.pc_sel = 1; o.ifid_flush = 1; bubble = 1;
        end else if (lu) begin
            o.pc_write = 0; o.ifid_write = 0; bubble = 1;
        end else if (i.jr) begin
            o.pc_sel = 3; o.ifid_flush = 1;
        end else if (i.jump) begin
            o.pc_sel = 2; o.ifid_flush = 1;
        end

        if (model_ok) begin
            o.ex_bits  = ex_bits_of(m_ex);
            o.ex_dst   = m_ex.dst;
            o.mem_bits = (int'(m_mem.mem_read) << 3) | (int'(m_mem.mem_write) << 2)
                       | (int'(m_mem.memto_reg) << 1) | int'(m_mem.reg_write);
            o.mem_dst  = m_mem.dst;
            o.wb_bits  = (int'(m_wb.memto_reg) << 1) | int'(m_wb.reg_write);
            o.wb_dst   = m_wb.dst;
            o.stall    = m_stall;
            o.flush    = m_flush;
            exp_q.push_back(o);
        end

        if (r) begin
            m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot();
            m_stall = 0; m_flush = 0; model_ok = 1;
        end else begin
            nxt = empty_slot();
            if (!bubble) begin
                nxt.reg_dst = i.reg_dst; nxt.alusrc = i.alusrc; nxt.branch = i.branch;
                nxt.mem_read = i.mem_read; nxt.mem_write = i.mem_write;
                nxt.memto_reg = i.memto_reg; nxt.reg_write = i.reg_write || i.jal;
                nxt.aluop = i.aluop;
                nxt.dst = i.jal ? 31 : (i.reg_dst ? i.rd : i.rt);
            end
            stall_ev = lu && !br;
            if (stall_ev && m_stall < CNT_MAX) m_stall++;
            if (o.ifid_flush && m_flush < CNT_MAX) m_flush++;
            m_wb = m_mem; m_mem = m_ex; m_ex = nxt;
        end
    endtask

    // Monitor: compares whatever the DUT shows against the oldest expectation.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ex_ctrl",    {23'd0, ex_RegDst, ex_ALUsrc, ex_Branch, ex_MemRead,
                                     ex_MemWrite, ex_MemtoReg, ex_RegWrite, ex_ALUop}, e.ex_bits);
                check("ex_dst",     int'(ex_dst), e.ex_dst);
                check("mem_ctrl",   {28'd0, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite}, e.mem_bits);
                check("mem_dst",    int'(mem_dst), e.mem_dst);
                check("wb_ctrl",    {30'd0, wb_MemtoReg, wb_RegWrite}, e.wb_bits);
                check("wb_dst",     int'(wb_dst), e.wb_dst);
                check("pc_sel",     int'(pc_sel), e.pc_sel);
                check("pc_write",   int'(pc_write), e.pc_write);
                check("ifid_write", int'(ifid_write), e.ifid_write);
                check("ifid_flush", int'(ifid_flush), e.ifid_flush);
                check("stall_cnt",  int'(stall_cnt), e.stall);
                check("flush_cnt",  int'(flush_cnt), e.flush);
            end
        end
    end

    function automatic inst_t lw(input int rt);
        inst_t i = nop();
        i.mem_read = 1; i.memto_reg = 1; i.alusrc = 1; i.reg_write = 1; i.rs = 1; i.rt = rt;
        return i;
    endfunction

    function automatic inst_t add(input int rs, input int rt, input int rd);
        inst_t i = nop();
        i.reg_dst = 1; i.reg_write = 1; i.aluop = 2; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic inst_t beq(input int rs, input int rt);
        inst_t i = nop();
        i.branch = 1; i.aluop = 1; i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic inst_t rand_inst();
        inst_t i;
        i.reg_dst = 1'($urandom); i.branch = ($urandom_range(0, 3) == 0);
        i.mem_read = ($urandom_range(0, 2) == 0); i.memto_reg = 1'($urandom);
        i.mem_write = ($urandom_range(0, 3) == 0); i.alusrc = 1'($urandom);
        i.reg_write = 1'($urandom); i.aluop = $urandom_range(0, 3);
        i.jump = ($urandom_range(0, 7) == 0); i.jal = i.jump && 1'($urandom);
        i.jr = !i.jump && ($urandom_range(0, 9) == 0);
        i.rs = $urandom_range(0, 3); i.rt = $urandom_range(0, 3); i.rd = $urandom_range(0, 31);
        return i;
    endfunction

    initial begin
        inst_t j;
        int    wait_cyc;
        rst = 1'b1; ex_zero = 1'b0;
        // Reset held two cycles.
        step(nop(), 0, 1);
        step(nop(), 0, 1);
        // Load-use: lw r8 then add using r8; the add is re-presented after the stall.
        step(lw(8), 0, 0);
        step(add(8, 2, 9), 0, 0);
        step(add(8, 2, 9), 0, 0);
        step(nop(), 0, 0);
        // Taken branch, then not-taken branch.
        step(beq(1, 2), 0, 0);
        step(add(3, 4, 5), 1, 0);
        step(beq(1, 2), 0, 0);
        step(add(3, 4, 5), 0, 0);
        // jal, then three cycles to reach WB.
        j = nop(); j.jump = 1; j.jal = 1;
        step(j, 0, 0);
        step(nop(), 0, 0);
        step(nop(), 0, 0);
        step(nop(), 0, 0);
        // jr squashed by a taken branch in EX.
        step(beq(2, 2), 0, 0);
        j = nop(); j.jr = 1; j.rs = 31;
        step(j, 1, 0);
        step(nop(), 0, 0);
        // Five load-use events drive stall_cnt into saturation.
        for (int k = 0; k < 5; k++) begin
            step(lw(4), 0, 0);
            step(add(4, 4, 6), 0, 0);
            step(add(4, 4, 6), 0, 0);
        end
        // Reset landing during a stall.
        step(lw(7), 0, 0);
        step(add(7, 0, 3), 0, 1);
        step(add(7, 0, 3), 0, 0);
        // Random traffic with occasional resets.
        for (int k = 0; k < 2000; k++)
            step(rand_inst(), 1'($urandom), ($urandom_range(0, 59) == 0));

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
